// File: rtl/mul_fp_feeder.sv
// mul_fp_feeder: operand feeder for the FP32 accumulator.
// Takes a programmed number of FP operand pairs over a valid/ready handshake.
// Each pair is multiplied (round-to-nearest-even, tininess detected after
// rounding, canonical quiet NaN on invalid). The product is sent to the
// accumulator as a one-cycle strobe. Exception flags are kept sticky for the run.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     start-run pulse, honoured only when idle
//   len_i       number of pairs in the run, sampled with start_i
//   a_i, b_i    operands; in_valid_i qualifies them
//   in_ready_o  a pair is accepted this cycle when in_valid_i is also high
//   summand_o   product, held between strobes
//   en_o        product strobe
//   busy_o      run or drain in progress
//   done_o      one-cycle completion pulse
//   flags_o     sticky {invalid, infinite, overflow, underflow, inexact}
module mul_fp_feeder #(
  parameter int unsigned EXPWIDTH = 8,
  parameter int unsigned SIGWIDTH = 24,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [LEN_W-1:0]             len_i,
  input  logic [EXPWIDTH+SIGWIDTH-1:0] a_i,
  input  logic [EXPWIDTH+SIGWIDTH-1:0] b_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [EXPWIDTH+SIGWIDTH-1:0] summand_o,
  output logic                         en_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [4:0]                   flags_o
);

  localparam int unsigned FW  = EXPWIDTH + SIGWIDTH;
  localparam int unsigned FRW = SIGWIDTH - 1;
  localparam int unsigned PW  = 2 * SIGWIDTH;
  localparam int unsigned XW  = EXPWIDTH + 3;  // signed working exponent

  localparam logic [EXPWIDTH-1:0]  EXP_MAX = '1;
  localparam logic [EXPWIDTH-1:0]  EXP_ONE = EXPWIDTH'(1);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXPWIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic signed [XW-1:0] ZERO    = '0;
  localparam logic signed [XW-1:0] PW_X    = XW'(PW);

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic                 nan;
    logic                 snan;
    logic signed [XW-1:0] eu;  // unbiased exponent of mn's MSB
    logic [SIGWIDTH-1:0]  mn;  // significand normalised to MSB set
  } op_t;

  // Classify an operand and normalise subnormals so every finite nonzero
  // operand has its leading one at the significand MSB.
  function automatic op_t unpack(input logic [FW-1:0] x);
    op_t                 o;
    logic [EXPWIDTH-1:0] e;
    logic [FRW-1:0]      f;
    logic [SIGWIDTH-1:0] m;
    logic [XW-1:0]       lz;
    e      = x[FW-2 -: EXPWIDTH];
    f      = x[FRW-1:0];
    o.sign = x[FW-1];
    o.zero = (e == '0) && (f == '0);
    o.inf  = (e == EXP_MAX) && (f == '0);
    o.nan  = (e == EXP_MAX) && (f != '0);
    o.snan = o.nan && !f[FRW-1];
    m      = {e != '0, f};
    lz     = '0;
    for (int i = 0; i < SIGWIDTH; i++) begin
      if (m[i]) lz = XW'(SIGWIDTH - 1 - i);
    end
    o.mn = m << lz;
    o.eu = $signed({3'b000, (e == '0) ? EXP_ONE : e}) - BIAS - $signed(lz);
    return o;
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic              ready_q, done_q, en_q;
  logic              s1_valid_q;
  logic [FW-1:0]     s1_a_q, s1_b_q, summand_q;
  logic [4:0]        flags_q;
  logic              accept;

  // Multiplier datapath, fed from stage 1
  op_t                  op_a, op_b;
  logic                 sign, invalid, ovf, tiny, inexact, guard, sticky, round_up;
  logic [PW-1:0]        prod, pn;
  logic signed [XW-1:0] e_u, eb, exp_pre;
  logic [XW-1:0]        sh, exp_fin;
  logic [2*PW-1:0]      shifted;
  logic [PW-1:0]        mant;
  logic [SIGWIDTH-1:0]  sig;
  logic [SIGWIDTH:0]    sig_r;
  logic [XW+FRW-1:0]    res_w;
  logic [FW-1:0]        mul_res;
  logic [4:0]           mul_flags;

  always_comb begin
    op_a    = unpack(s1_a_q);
    op_b    = unpack(s1_b_q);
    sign    = op_a.sign ^ op_b.sign;
    invalid = op_a.snan | op_b.snan | (op_a.inf & op_b.zero) | (op_a.zero & op_b.inf);

    prod = PW'(op_a.mn) * PW'(op_b.mn);
    if (prod[PW-1]) begin
      pn  = prod;
      e_u = $signed(op_a.eu) + $signed(op_b.eu) + ONE;
    end else begin
      pn  = prod << 1;
      e_u = $signed(op_a.eu) + $signed(op_b.eu);
    end
    eb = e_u + BIAS;

    // Results below the normal range are denormalised before rounding.
    sh = '0;
    if (eb < ONE) sh = (ONE - eb > PW_X) ? PW_X : ONE - eb;
    shifted  = {pn, {PW{1'b0}}} >> sh;
    mant     = shifted[2*PW-1:PW];
    sig      = mant[PW-1 -: SIGWIDTH];
    guard    = mant[SIGWIDTH-1];
    sticky   = (|mant[SIGWIDTH-2:0]) | (|shifted[PW-1:0]);
    round_up = guard & (sticky | sig[0]);
    sig_r    = {1'b0, sig} + (SIGWIDTH + 1)'(round_up);
    inexact  = guard | sticky;

    // The hidden bit adds into the exponent field, so a rounding carry or a
    // subnormal rounding up to the minimum normal falls out of the addition.
    exp_pre = (eb < ONE) ? ZERO : eb - ONE;
    res_w   = {exp_pre, {FRW{1'b0}}} + (XW + FRW)'(sig_r);
    exp_fin = res_w[XW+FRW-1:FRW];
    ovf     = exp_fin >= {3'b000, EXP_MAX};

    // Tiny after rounding: only eb == 0 can be rescued, when rounding to full
    // precision carries into the minimum normal exponent.
    tiny = (eb < ZERO) ||
           ((eb == ZERO) && !((&pn[PW-1 -: SIGWIDTH]) && pn[SIGWIDTH-1]));

    if (op_a.nan | op_b.nan | invalid) begin
      mul_res   = {1'b0, EXP_MAX, 1'b1, {(FRW - 1){1'b0}}};
      mul_flags = {invalid, 4'b0000};
    end else if (op_a.inf | op_b.inf) begin
      mul_res   = {sign, EXP_MAX, {FRW{1'b0}}};
      mul_flags = '0;
    end else if (op_a.zero | op_b.zero) begin
      mul_res   = {sign, {(FW - 1){1'b0}}};
      mul_flags = '0;
    end else if (ovf) begin
      mul_res   = {sign, EXP_MAX, {FRW{1'b0}}};
      mul_flags = 5'b00101;
    end else begin
      mul_res   = {sign, res_w[EXPWIDTH+FRW-1:0]};
      mul_flags = {3'b000, tiny & inexact, inexact};
    end
  end

  assign accept = in_valid_i && ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      summand_q  <= '0;
      flags_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q <= a_i;
        s1_b_q <= b_i;
      end
      en_q <= s1_valid_q;
      if (s1_valid_q) begin
        summand_q <= mul_res;
        flags_q   <= flags_q | mul_flags;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            flags_q <= '0;
            if (len_i != '0) begin
              len_q   <= len_i;
              cnt_q   <= '0;
              ready_q <= 1'b1;
              state_q <= StRun;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q + LEN_W'(1) == len_q) begin
              ready_q <= 1'b0;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Stage 1 empty means the strobe now in stage 2 is the last one.
          if (!s1_valid_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o = ready_q;
  assign summand_o  = summand_q;
  assign en_o       = en_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign flags_o    = flags_q;

endmodule

// File: tb/tb_mul_fp_feeder.sv
module tb_mul_fp_feeder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] len;
  logic [31:0] a, b;
  logic        in_ready, en, busy, done;
  logic [31:0] summand;
  logic [4:0]  flags;

  always #5 clk = ~clk;

  mul_fp_feeder #(.EXPWIDTH(8), .SIGWIDTH(24), .LEN_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .a_i        (a),
    .b_i        (b),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .summand_o  (summand),
    .en_o       (en),
    .busy_o     (busy),
    .done_o     (done),
    .flags_o    (flags)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cnt;
  int done_cnt;
  logic [31:0] prod_q[$];
  int en_cyc_q[$];
  int acc_cyc_q[$];

  task automatic clear_log();
    acc_cnt  = 0;
    done_cnt = 0;
    prod_q.delete();
    en_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  // Advance one clock; log accepts, strobes and done pulses.
  task automatic tick();
    if (in_valid && in_ready) begin
      acc_cnt++;
      acc_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (en) begin
      prod_q.push_back(summand);
      en_cyc_q.push_back(cyc);
    end
    if (done) done_cnt++;
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (done_cnt == 0 && k < 30) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; len = '0; a = '0; b = '0;
    tick();
    tick();
    obs = {in_ready, en, busy, done, flags, summand};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b in_ready=%b expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_single();
    clear_log();
    start_run(1);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: in_ready=%b busy=%b expected 1 1", in_ready, busy);
    end
    a = 32'h3FC0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: in_ready=%b en=%b expected 0 0", in_ready, en);
    end
    tick();
    n_tests++;
    if (en !== 1'b1 || summand !== 32'h4040_0000) begin
      n_fail++;
      $display("FAIL single_product: en=%b summand=%h expected 1 40400000", en, summand);
    end
    tick();
    n_tests++;
    if (en !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: en=%b done=%b expected 0 1", en, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || flags !== 5'b0 || prod_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_end: done=%b busy=%b flags=%b strobes=%0d expected 0 0 00000 1",
               done, busy, flags, prod_q.size());
    end
  endtask

  task automatic test_streaming();
    logic [31:0] av[5] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h0000_0000,
                           32'h4040_0000};
    logic [31:0] bv[5] = '{32'h3F80_0000, 32'h4080_0000, 32'h4000_0000, 32'h40A0_0000,
                           32'h4040_0000};
    logic [31:0] ev[4] = '{32'h3F80_0000, 32'hC080_0000, 32'h4080_0000, 32'h0000_0000};
    int idx;
    clear_log();
    start_run(4);
    in_valid = 1'b1;
    for (int k = 0; k < 16 && done_cnt == 0; k++) begin
      idx = (acc_cnt < 5) ? acc_cnt : 4;
      a = av[idx];
      b = bv[idx];
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (acc_cnt != 4 || prod_q.size() != 4 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL stream_counts: accepts=%0d strobes=%0d done=%0d expected 4 4 1",
               acc_cnt, prod_q.size(), done_cnt);
    end
    for (int i = 0; i < prod_q.size() && i < 4; i++) begin
      n_tests++;
      if (prod_q[i] !== ev[i] || en_cyc_q[i] != acc_cyc_q[0] + 1 + i) begin
        n_fail++;
        $display("FAIL stream_product%0d: got %h at cycle %0d expected %h at cycle %0d",
                 i, prod_q[i], en_cyc_q[i], ev[i], acc_cyc_q[0] + 1 + i);
      end
    end
    n_tests++;
    if (flags !== 5'b0) begin
      n_fail++;
      $display("FAIL stream_flags: got %b expected 00000", flags);
    end
  endtask

  task automatic test_exceptions();
    logic [31:0] p;
    clear_log();
    start_run(1);
    a = 32'h7F7F_FFFF; b = 32'h4000_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    p = (prod_q.size() > 0) ? prod_q[0] : 32'hDEAD_BEEF;
    n_tests++;
    if (p !== 32'h7F80_0000 || flags !== 5'b00101) begin
      n_fail++;
      $display("FAIL overflow: got %h flags %b expected 7f800000 00101", p, flags);
    end
    clear_log();
    start_run(1);
    n_tests++;
    if (flags !== 5'b0) begin
      n_fail++;
      $display("FAIL flags_clear: got %b expected 00000", flags);
    end
    a = 32'h7F80_0000; b = 32'h0000_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    p = (prod_q.size() > 0) ? prod_q[0] : 32'h0000_0000;
    n_tests++;
    if (p[30:23] !== 8'hFF || p[22:0] == '0 || flags !== 5'b10000) begin
      n_fail++;
      $display("FAIL inf_times_zero: got %h flags %b expected quiet NaN 10000", p, flags);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] av[3] = '{32'h3F80_0001, 32'h0080_0000, 32'h0080_0001};
    logic [31:0] bv[3] = '{32'h3F80_0001, 32'h3F00_0000, 32'h3F00_0000};
    logic [31:0] ev[3] = '{32'h3F80_0002, 32'h0040_0000, 32'h0040_0000};
    clear_log();
    start_run(3);
    in_valid = 1'b1;
    for (int k = 0; k < 8 && acc_cnt < 3; k++) begin
      a = av[acc_cnt];
      b = bv[acc_cnt];
      tick();
    end
    in_valid = 1'b0;
    drain();
    n_tests++;
    if (prod_q.size() != 3) begin
      n_fail++;
      $display("FAIL round_count: got %0d strobes expected 3", prod_q.size());
    end
    for (int i = 0; i < prod_q.size() && i < 3; i++) begin
      n_tests++;
      if (prod_q[i] !== ev[i]) begin
        n_fail++;
        $display("FAIL round_product%0d: got %h expected %h", i, prod_q[i], ev[i]);
      end
    end
    n_tests++;
    if (flags !== 5'b00011) begin
      n_fail++;
      $display("FAIL round_flags: got %b expected 00011", flags);
    end
  endtask

  task automatic test_gapped_and_empty();
    logic [31:0] ev[2] = '{32'h3FC0_0000, 32'h4080_0000};
    clear_log();
    start_run(2);
    a = 32'h4040_0000; b = 32'h3F00_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    a = 32'hC000_0000; b = 32'hC000_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    n_tests++;
    if (acc_cnt != 2 || prod_q.size() != 2 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL gap_counts: accepts=%0d strobes=%0d done=%0d expected 2 2 1",
               acc_cnt, prod_q.size(), done_cnt);
    end
    for (int i = 0; i < prod_q.size() && i < 2 && i < acc_cyc_q.size(); i++) begin
      n_tests++;
      if (prod_q[i] !== ev[i] || en_cyc_q[i] != acc_cyc_q[i] + 1) begin
        n_fail++;
        $display("FAIL gap_product%0d: got %h at cycle %0d expected %h at cycle %0d",
                 i, prod_q[i], en_cyc_q[i], ev[i], acc_cyc_q[i] + 1);
      end
    end
    clear_log();
    start_run(0);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_done: done=%b busy=%b expected 1 0", done, busy);
    end
    tick();
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || prod_q.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL len0_quiet: done=%b busy=%b strobes=%0d pulses=%0d expected 0 0 0 1",
               done, busy, prod_q.size(), done_cnt);
    end
  endtask

  task automatic test_start_busy();
    clear_log();
    start_run(3);
    a = 32'h3FC0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    tick();
    start = 1'b1; len = 16'd1;
    tick();
    start = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: in_ready=%b busy=%b expected 1 1", in_ready, busy);
    end
    drain();
    in_valid = 1'b0;
    n_tests++;
    if (acc_cnt != 3 || prod_q.size() != 3 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_counts: accepts=%0d strobes=%0d done=%0d expected 3 3 1",
               acc_cnt, prod_q.size(), done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [40:0] obs;
    clear_log();
    start_run(3);
    a = 32'h3FC0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {in_ready, en, busy, done, flags, summand};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 0", obs);
    end
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    n_tests++;
    if (prod_q.size() != 0 || acc_cnt != 1 || busy !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: strobes=%0d accepts=%0d busy=%b done=%0d expected 0 1 0 0",
               prod_q.size(), acc_cnt, busy, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_exceptions();
    test_rounding();
    test_gapped_and_empty();
    test_start_busy();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mul_fp_feeder.md
Name: mul_fp_feeder

Overview:
- Upstream stage of the FP32 accumulator (adder_fp).
- Accepts a stream of FP32 operand pairs over a valid/ready handshake and multiplies each pair (IEEE-754 binary32, round-to-nearest-even, HardFloat recoded multiplier).
- Drives the accumulator's summand and enable as a one-cycle product strobe.
- Counts a programmed vector length, signals completion once the last product has been issued, and keeps sticky exception flags for the run.

Parameters:
- EXPWIDTH, 8, exponent width of the FP format.
- SIGWIDTH, 24, significand width including hidden bit.
- LEN_W, 16, width of the vector-length and element counters.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  start-run pulse; sampled only in IDLE.
- len_i  input  LEN_W  number of pairs in the run; sampled with start_i.
- a_i  input  32  FP32 operand A.
- b_i  input  32  FP32 operand B.
- in_valid_i  input  1  a_i/b_i valid.
- in_ready_o  output  1  block accepts a pair this cycle.
- summand_o  output  32  FP32 product, to the accumulator summand input.
- en_o  output  1  product strobe, to the accumulator enable.
- busy_o  output  1  high in RUN or DRAIN.
- done_o  output  1  one-cycle pulse when the run is complete.
- flags_o  output  5  sticky {invalid, infinite, overflow, underflow, inexact}.

Behaviour:
- Reset (rst_i high at a clock edge): state=IDLE, counters=0, pipeline valids=0, summand_o=0, en_o=0, in_ready_o=0, busy_o=0, done_o=0, flags_o=0. Reset mid-run aborts the run; in-flight products are discarded and no en_o follows.
- State machine:
  - IDLE: on start_i with len_i!=0, latch len, clear the accept counter and flags_o, go to RUN. On start_i with len_i==0, clear flags_o and pulse done_o next cycle; stay IDLE; no en_o.
  - RUN: in_ready_o=1 while accepted<len. A pair is accepted on in_valid_i&&in_ready_o; accepted increments. When the accept making accepted==len occurs, go to DRAIN; in_ready_o drops the following cycle, so exactly len pairs are taken.
  - DRAIN: in_ready_o=0. When both pipeline stages are empty, go to IDLE and pulse done_o for one cycle, in the cycle after the last en_o.
- start_i outside IDLE is ignored. in_valid_i while in_ready_o=0 is ignored; no pair is lost or duplicated.
- Pipeline, 2 stages, no stalls (the accumulator has no backpressure):
  - S1 registers a_i, b_i and valid on accept.
  - S2 registers summand_o = recFNToFN(mulRecFN(fNToRecFN(A), fNToRecFN(B))) together with en_o = S1 valid.
  - Latency: pair accepted at edge N gives en_o high for the cycle after edge N+1. Back-to-back accepts give back-to-back en_o; throughput is 1 pair/cycle.
- summand_o holds its last value when en_o=0.
- Rounding and tininess: round_near_even, tininess after rounding, subtraction unused.
- flags_o: bitwise OR of the multiplier exception flags of every product with a valid S2 output this run. Cleared only on start and reset. Stable after done_o until the next start.
- busy_o = (state!=IDLE).

Test Plan:
- Single pair: reset, start_i with len=1, A=0x3FC00000 (1.5), B=0x40000000 (2.0) → in_ready_o high 1 cycle; en_o exactly once, 2 cycles after accept, summand_o=0x40400000; done_o next cycle; flags_o=0.
- Streaming: len=4 with in_valid_i held high, pairs (1,1), (-1.0=0xBF800000, 4.0=0x40800000), (2,2), (0,5) → exactly 4 accepts, 4 consecutive en_o with summand_o = 0x3F800000, 0xC0800000, 0x40800000, 0x00000000; a 5th presented pair is not accepted; the downstream accumulator reads 1.0.
- Exceptions:
  - 0x7F7FFFFF × 2.0 → summand_o=0x7F800000, flags_o=5'b00101.
  - A following run with +inf (0x7F800000) × 0 → quiet NaN output (exponent 0xFF, fraction≠0), flags_o=5'b10000 (cleared by start).
- Gapped input and len=0: toggle in_valid_i 1-0-1 for len=2 → en_o pulses mirror the accepts with 2-cycle latency. start_i with len=0 → done_o one cycle later, no en_o, busy_o stays 0.
- Start while busy: assert start_i during RUN → ignored; original count completes.
- Reset mid-run: rst_i high at RUN with 1 product in flight → next cycle all outputs 0 and state IDLE; no en_o afterwards.
